// File: rtl/game_state_tx.sv
// game_state_tx: UART 8N1 transmitter for a 4-byte game-state snapshot.
// Frame: 0xA5 header, packed lives/door/position byte, position/time_up byte,
// then an XOR checksum of the first three bytes. Bytes go out back-to-back,
// LSB first, each wrapped in a start bit (0) and a stop bit (1).
module game_state_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [1:0] p1_lives,
    input  logic [1:0] p2_lives,
    input  logic [1:0] correct_door,
    input  logic [1:0] player_1_pos,
    input  logic [1:0] player_2_pos,
    input  logic       time_up,
    output logic       serial_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    HEADER    = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_reg,  state_next;
    logic [CW-1:0]   baud_reg,   baud_next;
    logic [2:0]      bit_reg,    bit_next;
    logic [1:0]      byte_reg,   byte_next;
    logic [10:0]     snap_reg,   snap_next;
    logic            serial_reg, serial_next;
    logic            busy_reg,   busy_next;
    logic            done_reg,   done_next;

    logic            baud_wrap;
    logic [7:0]      byte_1;
    logic [7:0]      byte_2;
    logic [7:0]      byte_3;
    logic [7:0]      cur_byte;
    logic [2:0]      bit_inc;

    // Payload bytes come straight from the snapshot so the line never sees live inputs.
    assign byte_1 = snap_reg[10:3];
    assign byte_2 = {snap_reg[2:0], 5'b00000};

    // Checksum is a bitwise XOR of header and both payload bytes.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_checksum
            assign byte_3[gi] = HEADER[gi] ^ byte_1[gi] ^ byte_2[gi];
        end
    endgenerate

    assign baud_wrap = (baud_reg == BAUD_LAST);
    assign bit_inc   = bit_reg + 3'd1;

    // Select the byte currently on the wire.
    always_comb begin
        cur_byte = HEADER;
        case (byte_reg)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = byte_1;
            2'd2:    cur_byte = byte_2;
            default: cur_byte = byte_3;
        endcase
    end

    // Next-state logic: counters advance each cycle, bit transitions only on baud wrap.
    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        byte_next   = byte_reg;
        snap_next   = snap_reg;
        serial_next = serial_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;

        if (state_reg != IDLE) begin
            baud_next = baud_wrap ? '0 : baud_reg + CW'(1);
        end

        case (state_reg)
            IDLE: begin
                serial_next = 1'b1;
                busy_next   = 1'b0;
                if (send && !busy_reg) begin
                    snap_next   = {p1_lives, p2_lives, correct_door, player_1_pos,
                                   player_2_pos, time_up};
                    state_next  = START;
                    baud_next   = '0;
                    bit_next    = 3'd0;
                    byte_next   = 2'd0;
                    serial_next = 1'b0;
                    busy_next   = 1'b1;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_next  = DATA;
                    bit_next    = 3'd0;
                    serial_next = cur_byte[0];
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (bit_reg == 3'd7) begin
                        state_next  = STOP;
                        serial_next = 1'b1;
                    end else begin
                        bit_next    = bit_inc;
                        serial_next = cur_byte[bit_inc];
                    end
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (byte_reg == 2'd3) begin
                        state_next  = IDLE;
                        serial_next = 1'b1;
                        busy_next   = 1'b0;
                        done_next   = 1'b1;
                    end else begin
                        state_next  = START;
                        byte_next   = byte_reg + 2'd1;
                        serial_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                serial_next = 1'b1;
                busy_next   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= 3'd0;
            byte_reg   <= 2'd0;
            snap_reg   <= '0;
            serial_reg <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            byte_reg   <= byte_next;
            snap_reg   <= snap_next;
            serial_reg <= serial_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign serial_out = serial_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;

endmodule

// File: tb/tb_game_state_tx.sv
// Directed testbench for game_state_tx with CLKS_PER_BIT = 4.
module tb_game_state_tx;

    localparam int C     = 4;
    localparam int FRAME = 40 * C;

    logic       clk;
    logic       reset;
    logic       send;
    logic [1:0] p1_lives;
    logic [1:0] p2_lives;
    logic [1:0] correct_door;
    logic [1:0] player_1_pos;
    logic [1:0] player_2_pos;
    logic       time_up;
    logic       serial_out;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    logic       line_s [FRAME];
    logic [7:0] rx_bytes [4];
    int         rx_busy_low;
    int         rx_done_seen;
    bit         rx_framing_ok;

    game_state_tx #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .send         (send),
        .p1_lives     (p1_lives),
        .p2_lives     (p2_lives),
        .correct_door (correct_door),
        .player_1_pos (player_1_pos),
        .player_2_pos (player_2_pos),
        .time_up      (time_up),
        .serial_out   (serial_out),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_inputs(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                              input logic [1:0] p1, input logic [1:0] p2, input logic t);
        p1_lives     = a;
        p2_lives     = b;
        correct_door = d;
        player_1_pos = p1;
        player_2_pos = p2;
        time_up      = t;
    endtask

    // Raise send before an edge; that edge is the accept cycle N. Optionally keep it high.
    task automatic issue_send(input bit hold);
        @(negedge clk);
        send = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) send = 1'b0;
    endtask

    // Record cycles N+1 .. N+40*C and decode the four bytes from bit centres.
    task automatic capture_frame();
        rx_busy_low   = 0;
        rx_done_seen  = 0;
        rx_framing_ok = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            line_s[i] = serial_out;
            if (busy !== 1'b1) rx_busy_low++;
            if (frame_done !== 1'b0) rx_done_seen++;
        end
        for (int k = 0; k < 40; k++) begin
            for (int j = 1; j < C; j++) begin
                if (line_s[k*C+j] !== line_s[k*C]) rx_framing_ok = 1'b0;
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (line_s[b*10*C] !== 1'b0) rx_framing_ok = 1'b0;
            if (line_s[b*10*C + 9*C] !== 1'b1) rx_framing_ok = 1'b0;
            for (int i = 0; i < 8; i++) rx_bytes[b][i] = line_s[b*10*C + (1+i)*C + 2];
        end
    endtask

    task automatic test_reset();
        int errs;
        reset = 1'b1;
        send  = 1'b0;
        set_inputs(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({serial_out, busy, frame_done} !== 3'b100) begin
            bad++;
            $display("FAIL reset_state: got so/busy/done=%b required 100", {serial_out, busy, frame_done});
        end
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({serial_out, busy, frame_done} !== 3'b100) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL idle_after_reset: got %0d bad cycles required 0", errs);
        end
        $display("test_reset: idle line checked for 20 cycles");
    endtask

    task automatic check_frame(input string name, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3);
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hA5; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
        for (int b = 0; b < 4; b++) begin
            total++;
            if (rx_bytes[b] !== exp_b[b]) begin
                bad++;
                $display("FAIL %s_byte%0d: got %02h required %02h", name, b, rx_bytes[b], exp_b[b]);
            end
        end
        total++;
        if (!rx_framing_ok) begin
            bad++;
            $display("FAIL %s_framing: got bad start/stop or mid-bit change required clean bits", name);
        end
        total++;
        if (rx_busy_low != 0 || rx_done_seen != 0) begin
            bad++;
            $display("FAIL %s_busy: got busy_low=%0d early_done=%0d required 0 0", name,
                     rx_busy_low, rx_done_seen);
        end
        // Cycle N+40*C+1: frame_done pulse, line idle, not busy.
        @(negedge clk);
        total++;
        if ({serial_out, busy, frame_done} !== 3'b101) begin
            bad++;
            $display("FAIL %s_done: got so/busy/done=%b required 101", name, {serial_out, busy, frame_done});
        end
        $display("%s: bytes %02h %02h %02h %02h", name, rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]);
    endtask

    task automatic test_single_frame();
        set_inputs(2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 1'b1);
        issue_send(1'b0);
        capture_frame();
        check_frame("single", 8'hB4, 8'hA0, 8'hB1);
        @(negedge clk);
        total++;
        if ({serial_out, busy, frame_done} !== 3'b100) begin
            bad++;
            $display("FAIL single_after: got so/busy/done=%b required 100", {serial_out, busy, frame_done});
        end
    endtask

    task automatic test_ignore_while_busy();
        int errs;
        set_inputs(2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 1'b1);
        issue_send(1'b0);
        fork
            capture_frame();
            begin
                repeat (9) @(negedge clk);
                set_inputs(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        check_frame("ignore", 8'hB4, 8'hA0, 8'hB1);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || serial_out !== 1'b1 || frame_done !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL ignore_no_second: got %0d active cycles required 0", errs);
        end
    endtask

    task automatic test_back_to_back();
        int errs;
        set_inputs(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        issue_send(1'b1);
        capture_frame();
        check_frame("b2b_first", 8'h00, 8'h00, 8'hA5);
        fork
            capture_frame();
            begin
                repeat (5) @(negedge clk);
                send = 1'b0;
            end
        join
        check_frame("b2b_second", 8'h00, 8'h00, 8'hA5);
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL b2b_no_third: got %0d busy cycles required 0", errs);
        end
    endtask

    task automatic test_reset_mid_frame();
        int errs;
        set_inputs(2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 1'b1);
        issue_send(1'b0);
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({serial_out, busy, frame_done} !== 3'b100) begin
            bad++;
            $display("FAIL midreset_state: got so/busy/done=%b required 100", {serial_out, busy, frame_done});
        end
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            if ({serial_out, busy, frame_done} !== 3'b100) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL midreset_quiet: got %0d non-idle cycles required 0", errs);
        end
        issue_send(1'b0);
        capture_frame();
        check_frame("after_reset", 8'hB4, 8'hA0, 8'hB1);
    endtask

    task automatic test_all_ones();
        set_inputs(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1);
        issue_send(1'b0);
        capture_frame();
        check_frame("all_ones", 8'hFF, 8'hE0, 8'hBA);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_all_ones();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion required finish before limit");
        $fatal(1, "timeout");
    end

endmodule
